// File: rtl/timer_event_logger.sv
// Captures timer capture/alarm rising edges, tags them and queues them in a show-ahead FIFO.
// Define TIMER_EVT_TIMESTAMP_EN to store a per-entry timestamp on evt_stamp.
module timer_event_logger #(
  parameter int DEPTH  = 8,
  parameter int DROP_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     capture,
  input  logic [31:0]              counter,
  input  logic                     alarm_out,
  input  logic [31:0]              alarm,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [1:0]               evt_type,
  output logic [31:0]              evt_data,
  output logic [31:0]              evt_stamp,
  output logic [$clog2(DEPTH):0]   fill,
  output logic [DROP_W-1:0]        drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] TYPE_CAPTURE = 2'b01;
  localparam logic [1:0] TYPE_ALARM   = 2'b10;

  logic              r_cap_d, r_alm_d;
  logic              r_cap_pend, r_alm_pend;
  logic [31:0]       r_cap_data, r_alm_data;
  logic [AW:0]       r_wr_ptr, r_rd_ptr;
  logic [DROP_W-1:0] r_drop;

  logic [1:0]        r_mem_type [DEPTH];
  logic [31:0]       r_mem_data [DEPTH];

  logic              w_cap_rise, w_alm_rise;
  logic              w_empty, w_full, w_pop, w_can_write;
  logic              w_wr_cap, w_wr_alm, w_push;
  logic              w_cap_drop, w_alm_drop;
  logic [1:0]        w_drops;
  logic [DROP_W:0]   w_drop_sum;
  logic [AW-1:0]     w_rd_idx, w_wr_idx;

  assign w_cap_rise  = capture & ~r_cap_d;
  assign w_alm_rise  = alarm_out & ~r_alm_d;

  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop       = ~flush & ~w_empty & evt_ready;
  assign w_can_write = ~flush & (~w_full | w_pop);

  // Capture wins the single write port; alarm waits a cycle behind it.
  assign w_wr_cap    = r_cap_pend & w_can_write;
  assign w_wr_alm    = r_alm_pend & ~r_cap_pend & w_can_write;
  assign w_push      = w_wr_cap | w_wr_alm;

  // A rise is lost only if the source's slot is occupied and not draining this cycle.
  assign w_cap_drop  = ~flush & w_cap_rise & r_cap_pend & ~w_wr_cap;
  assign w_alm_drop  = ~flush & w_alm_rise & r_alm_pend & ~w_wr_alm;
  assign w_drops     = {1'b0, w_cap_drop} + {1'b0, w_alm_drop};
  assign w_drop_sum  = {1'b0, r_drop} + {{(DROP_W-1){1'b0}}, w_drops};

  assign w_rd_idx    = r_rd_ptr[AW-1:0];
  assign w_wr_idx    = r_wr_ptr[AW-1:0];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cap_d    <= 1'b1;
      r_alm_d    <= 1'b1;
      r_cap_pend <= 1'b0;
      r_alm_pend <= 1'b0;
      r_cap_data <= '0;
      r_alm_data <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_drop     <= '0;
    end else begin
      r_cap_d <= capture;
      r_alm_d <= alarm_out;
      r_drop  <= w_drop_sum[DROP_W] ? {DROP_W{1'b1}} : w_drop_sum[DROP_W-1:0];
      if (flush) begin
        r_cap_pend <= 1'b0;
        r_alm_pend <= 1'b0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
      end else begin
        if (w_cap_rise && (!r_cap_pend || w_wr_cap)) begin
          r_cap_pend <= 1'b1;
          r_cap_data <= counter;
        end else if (w_wr_cap) begin
          r_cap_pend <= 1'b0;
        end
        if (w_alm_rise && (!r_alm_pend || w_wr_alm)) begin
          r_alm_pend <= 1'b1;
          r_alm_data <= alarm;
        end else if (w_wr_alm) begin
          r_alm_pend <= 1'b0;
        end
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // NOTE: FIFO storage has no reset; entries are only visible between valid pointers, and outputs are gated when empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_type[w_wr_idx] <= w_wr_cap ? TYPE_CAPTURE : TYPE_ALARM;
      r_mem_data[w_wr_idx] <= w_wr_cap ? r_cap_data : r_alm_data;
    end
  end

`ifdef TIMER_EVT_TIMESTAMP_EN
  logic [31:0] r_cap_stamp, r_alm_stamp;
  logic [31:0] r_mem_stamp [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cap_stamp <= '0;
      r_alm_stamp <= '0;
    end else if (!flush) begin
      if (w_cap_rise && (!r_cap_pend || w_wr_cap)) r_cap_stamp <= counter;
      if (w_alm_rise && (!r_alm_pend || w_wr_alm)) r_alm_stamp <= counter;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem_stamp[w_wr_idx] <= w_wr_cap ? r_cap_stamp : r_alm_stamp;
  end

  assign evt_stamp = w_empty ? '0 : r_mem_stamp[w_rd_idx];
`else
  assign evt_stamp = '0;
`endif

  assign evt_valid = ~w_empty;
  assign evt_type  = w_empty ? 2'b00 : r_mem_type[w_rd_idx];
  assign evt_data  = w_empty ? 32'd0 : r_mem_data[w_rd_idx];
  assign fill      = r_wr_ptr - r_rd_ptr;
  assign drop_cnt  = r_drop;

endmodule

// File: tb/tb_timer_event_logger.sv
// Directed bench for timer_event_logger: edge detection, arbitration, full/drop, flush and reset.
module tb_timer_event_logger;

  logic        clk = 1'b0;
  logic        rst, flush, capture, alarm_out, evt_ready;
  logic [31:0] counter, alarm;
  logic        evt_valid;
  logic [1:0]  evt_type;
  logic [31:0] evt_data, evt_stamp;
  logic [3:0]  fill;
  logic [15:0] drop_cnt;

  int checks   = 0;
  int failures = 0;

  timer_event_logger #(.DEPTH(8), .DROP_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .capture   (capture),
    .counter   (counter),
    .alarm_out (alarm_out),
    .alarm     (alarm),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_type  (evt_type),
    .evt_data  (evt_data),
    .evt_stamp (evt_stamp),
    .fill      (fill),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_capture(input logic [31:0] value);
    counter = value;
    capture = 1'b1;
    tick();
    capture = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; capture = 1'b1; alarm_out = 1'b0;
    evt_ready = 1'b0; counter = 32'd0; alarm = 32'd0;
    tick(); tick();
    checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", evt_valid); end
    checks++; if (evt_type !== 2'b00) begin failures++; $display("FAIL reset_type got=%0b exp=00", evt_type); end
    rst = 1'b0;
    tick(); tick(); tick();
    checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL release_valid got=%0b exp=0", evt_valid); end
    checks++; if (fill !== 4'd0) begin failures++; $display("FAIL release_fill got=%0d exp=0", fill); end
    checks++; if (drop_cnt !== 16'd0) begin failures++; $display("FAIL release_drop got=%0d exp=0", drop_cnt); end
    capture = 1'b0;
    tick();
  endtask

  task automatic test_capture();
    evt_ready = 1'b1;
    counter = 32'd100;
    capture = 1'b1;
    tick();
    capture = 1'b0;
    counter = 32'd101;
    checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL cap_early_valid got=%0b exp=0", evt_valid); end
    tick();
    checks++; if (evt_valid !== 1'b1) begin failures++; $display("FAIL cap_valid got=%0b exp=1", evt_valid); end
    checks++; if (evt_type !== 2'b01) begin failures++; $display("FAIL cap_type got=%0b exp=01", evt_type); end
    checks++; if (evt_data !== 32'd100) begin failures++; $display("FAIL cap_data got=%0d exp=100", evt_data); end
`ifdef TIMER_EVT_TIMESTAMP_EN
    checks++; if (evt_stamp !== 32'd100) begin failures++; $display("FAIL cap_stamp got=%0d exp=100", evt_stamp); end
`else
    checks++; if (evt_stamp !== 32'd0) begin failures++; $display("FAIL cap_stamp got=%0d exp=0", evt_stamp); end
`endif
    tick();
    checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL cap_popped got=%0b exp=0", evt_valid); end
    evt_ready = 1'b0;
  endtask

  task automatic test_alarm();
    evt_ready = 1'b0;
    counter = 32'd77;
    alarm = 32'hDEAD_BEEF;
    alarm_out = 1'b1;
    tick();
    alarm_out = 1'b0;
    alarm = 32'd0;
    tick();
    checks++; if (evt_type !== 2'b10) begin failures++; $display("FAIL alm_type got=%0b exp=10", evt_type); end
    checks++; if (evt_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL alm_data got=%h exp=deadbeef", evt_data); end
`ifdef TIMER_EVT_TIMESTAMP_EN
    checks++; if (evt_stamp !== 32'd77) begin failures++; $display("FAIL alm_stamp got=%0d exp=77", evt_stamp); end
`endif
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    checks++; if (fill !== 4'd0) begin failures++; $display("FAIL alm_drain_fill got=%0d exp=0", fill); end
  endtask

  task automatic test_simultaneous();
    evt_ready = 1'b0;
    counter = 32'd56; alarm = 32'd55;
    capture = 1'b1; alarm_out = 1'b1;
    tick();
    capture = 1'b0; alarm_out = 1'b0;
    counter = 32'd999; alarm = 32'd998;
    tick();
    checks++; if (fill !== 4'd1) begin failures++; $display("FAIL sim_fill1 got=%0d exp=1", fill); end
    checks++; if (evt_type !== 2'b01 || evt_data !== 32'd56) begin failures++; $display("FAIL sim_head1 got=%0b/%0d exp=01/56", evt_type, evt_data); end
    tick();
    checks++; if (fill !== 4'd2) begin failures++; $display("FAIL sim_fill2 got=%0d exp=2", fill); end
    evt_ready = 1'b1;
    tick();
    checks++; if (evt_type !== 2'b10 || evt_data !== 32'd55) begin failures++; $display("FAIL sim_head2 got=%0b/%0d exp=10/55", evt_type, evt_data); end
    tick();
    checks++; if (evt_valid !== 1'b0 || fill !== 4'd0) begin failures++; $display("FAIL sim_empty got=%0b/%0d exp=0/0", evt_valid, fill); end
    evt_ready = 1'b0;
  endtask

  task automatic test_fill_drop();
    evt_ready = 1'b0;
    for (int i = 0; i < 10; i++) pulse_capture(32'd200 + 32'(i));
    checks++; if (fill !== 4'd8) begin failures++; $display("FAIL full_fill got=%0d exp=8", fill); end
    checks++; if (drop_cnt !== 16'd1) begin failures++; $display("FAIL full_drop got=%0d exp=1", drop_cnt); end
    checks++; if (evt_data !== 32'd200) begin failures++; $display("FAIL full_head got=%0d exp=200", evt_data); end
  endtask

  task automatic test_full_push_pop();
    evt_ready = 1'b1;
    tick();
    checks++; if (fill !== 4'd8) begin failures++; $display("FAIL pushpop_fill got=%0d exp=8", fill); end
    for (int j = 1; j <= 8; j++) begin
      checks++;
      if (evt_valid !== 1'b1 || evt_data !== 32'd200 + 32'(j))
        begin failures++; $display("FAIL drain_%0d got=%0b/%0d exp=1/%0d", j, evt_valid, evt_data, 200 + j); end
      tick();
    end
    checks++; if (evt_valid !== 1'b0 || fill !== 4'd0) begin failures++; $display("FAIL drain_empty got=%0b/%0d exp=0/0", evt_valid, fill); end
    checks++; if (drop_cnt !== 16'd1) begin failures++; $display("FAIL drain_drop got=%0d exp=1", drop_cnt); end
    evt_ready = 1'b0;
  endtask

  task automatic test_flush();
    evt_ready = 1'b0;
    for (int i = 0; i < 3; i++) pulse_capture(32'd300 + 32'(i));
    checks++; if (fill !== 4'd3) begin failures++; $display("FAIL preflush_fill got=%0d exp=3", fill); end
    flush = 1'b1;
    counter = 32'd400;
    capture = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (evt_valid !== 1'b0 || fill !== 4'd0) begin failures++; $display("FAIL flush_empty got=%0b/%0d exp=0/0", evt_valid, fill); end
    checks++; if (drop_cnt !== 16'd1) begin failures++; $display("FAIL flush_drop got=%0d exp=1", drop_cnt); end
    capture = 1'b0;
    tick(); tick(); tick();
    checks++; if (fill !== 4'd0) begin failures++; $display("FAIL flush_capture got=%0d exp=0", fill); end
  endtask

  task automatic test_reset_mid();
    pulse_capture(32'd500);
    pulse_capture(32'd501);
    #2 rst = 1'b1;
    #1;
    checks++; if (fill !== 4'd0 || evt_valid !== 1'b0) begin failures++; $display("FAIL midrst_fifo got=%0d/%0b exp=0/0", fill, evt_valid); end
    checks++; if (drop_cnt !== 16'd0) begin failures++; $display("FAIL midrst_drop got=%0d exp=0", drop_cnt); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_capture();
    test_alarm();
    test_simultaneous();
    test_fill_drop();
    test_full_push_pop();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer_event_logger.md
Name: timer_event_logger

Overview:
Downstream consumer of the 32-bit timer. Detects capture and alarm events from the timer's control and status signals and tags each event with a type code and a data word. Buffers tagged events in a show-ahead FIFO and presents them on a valid/ready read port for software or trace logic. Events that cannot be stored are counted in a saturating drop counter.

Parameters:
DEPTH, 8, FIFO entries; power of 2, minimum 2.
DROP_W, 16, width of the saturating drop counter.

Ports:
clk  in  1  single clock, all logic on the rising edge.
rst  in  1  asynchronous, active-high reset.
flush  in  1  synchronous clear of the FIFO and pending flags.
capture  in  1  timer capture request, level; the rising edge is the event.
counter  in  32  timer counter value.
alarm_out  in  1  timer alarm output, level; the rising edge is the event.
alarm  in  32  timer alarm compare value.
evt_valid  out  1  FIFO head is valid.
evt_ready  in  1  consumer accepts the head.
evt_type  out  2  01 = CAPTURE, 10 = ALARM; 00 when the FIFO is empty.
evt_data  out  32  event data word.
evt_stamp  out  32  timestamp of the event (see Optional Feature).
fill  out  $clog2(DEPTH)+1  number of FIFO entries occupied.
drop_cnt  out  DROP_W  count of events lost.

Behaviour:
- Reset (asynchronous, active-high) sets:
  - all outputs to 0;
  - the capture_r and alarm_r edge registers to 1, so a level already high at reset release is not an event;
  - the FIFO pointers to 0 and both pending flags to 0.
- Edge detection:
  - cap_rise = capture & ~capture_r.
  - alm_rise = alarm_out & ~alarm_r.
  - capture_r and alarm_r are registered every cycle.
- Event payload latches into a per-source pending register on the rise cycle:
  - CAPTURE: data = counter sampled on the rise edge. This equals the value the timer latches into captured.
  - ALARM: data = alarm.
  - Timestamp = counter in both cases.
- Per-source pending flag:
  - Set on a rise.
  - Cleared when the pending event is written to the FIFO.
  - A rise while that source's flag is still set: the new event is dropped and the held payload is kept.
- Write arbiter, at most one FIFO write per cycle:
  - CAPTURE pending has priority over ALARM pending.
  - A write occurs only if the FIFO is not full, or a pop happens in the same cycle.
- A pending event is writable on the cycle after its rise.
  - A lone event into an empty FIFO raises evt_valid 2 cycles after the rise edge.
  - If capture and alarm rise together, CAPTURE is written first and ALARM on the following cycle.
- FIFO:
  - Show-ahead: evt_type, evt_data and evt_stamp reflect the head whenever evt_valid = 1.
  - Pop occurs on evt_valid & evt_ready.
  - evt_ready while empty is ignored.
  - Push and pop in the same cycle when full are legal: fill is unchanged and the head advances.
  - Pointers wrap modulo DEPTH; full and empty are distinguished by an extra pointer MSB.
- drop_cnt:
  - Increments by 1 per dropped event and saturates at all-ones.
  - Two drops in one cycle increment by 2, still saturating.
  - Cleared only by rst.
- flush:
  - Empties the FIFO and clears both pending flags in the next cycle.
  - drop_cnt is unchanged.
  - A rise in the flush cycle is discarded and not counted.
  - flush has priority over push and pop.
- rst mid-operation aborts everything immediately; no partial entries survive.

Optional Feature:
TIMER_EVT_TIMESTAMP_EN
- Defined: each entry stores a 32-bit timestamp, and evt_stamp outputs the head's timestamp.
- Undefined: no timestamp storage is built, evt_stamp is tied to 0, and the port list is unchanged.

Test Plan:
- Reset release with capture = 1 held: no event; evt_valid = 0, fill = 0, drop_cnt = 0.
- capture rises with counter = 100, evt_ready = 1: evt_valid goes high 2 cycles later with evt_type = 01 and evt_data = 100. With TIMER_EVT_TIMESTAMP_EN, evt_stamp = 100.
- capture and alarm_out rise in the same cycle, alarm = 55, counter = 56: first entry type 01 data 56, second entry type 10 data 55, on consecutive cycles; fill reaches 2 with evt_ready = 0.
- evt_ready = 0, 8 capture pulses spaced 3 cycles apart (DEPTH = 8), then 2 more: fill = 8. The 9th pulse is held pending and the 10th increments drop_cnt to 1. Raising evt_ready drains 9 entries in order.
- FIFO full, evt_ready = 1 in the same cycle as a pending write: fill stays 8 and the head advances.
- FIFO holds 3 entries, flush = 1 for one cycle: next cycle evt_valid = 0, fill = 0, drop_cnt unchanged; a capture in the flush cycle produces no entry.
